// File: rtl/ap_mult_pkg.sv
// Shared constants and row type for the 12x12 approximate Wallace multiplier datapath.
package ap_mult_pkg;

    localparam int AP_W     = 24;
    localparam int AP_SPLIT = 12;

    typedef logic [AP_W-1:0] ap_row_t;

endpackage

// File: rtl/ap_pipe_slice.sv
// One valid/ready register stage. It accepts a new beat whenever it is empty or its
// current beat leaves. The payload holds its value while the stage is stalled or idle.
module ap_pipe_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [PW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [PW-1:0] dn_data
);

    logic          valid_reg;
    logic [PW-1:0] data_reg;

    // A full stage can still accept a beat in the same cycle its current beat leaves.
    assign up_ready = !valid_reg || dn_ready;
    assign dn_valid = valid_reg;
    assign dn_data  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (up_ready) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                data_reg <= up_data;
            end
        end
    end

endmodule

// File: rtl/ap_cpa_pipe_24b.sv
// Final carry-propagate adder of the approximate multiplier, split into two registered halves:
// the low SPLIT bits are added in stage 1, and the high bits plus the carry are added in stage 2.
module ap_cpa_pipe_24b
    import ap_mult_pkg::*;
#(
    parameter int W     = AP_W,
    parameter int SPLIT = AP_SPLIT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_row0,
    input  logic [W-1:0] in_row1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_prod,
    output logic         out_ovf
);

    localparam int HW  = W - SPLIT;
    localparam int S1W = SPLIT + 1 + 2 * HW;
    localparam int S2W = W + 1;

    // Stage 1 payload layout: {h1, h0, c, lo}
    logic [SPLIT:0]   lo_sum;
    logic [S1W-1:0]   s1_in_data;
    logic             s1_valid;
    logic [S1W-1:0]   s1_data;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HW-1:0]    s1_h0;
    logic [HW-1:0]    s1_h1;
    logic [HW:0]      hi_sum;
    logic [S2W-1:0]   s2_in_data;
    logic             s2_adv;
    logic [S2W-1:0]   s2_data;

    assign lo_sum     = {1'b0, in_row0[SPLIT-1:0]} + {1'b0, in_row1[SPLIT-1:0]};
    assign s1_in_data = {in_row1[W-1:SPLIT], in_row0[W-1:SPLIT], lo_sum};

    ap_pipe_slice #(.PW(S1W)) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (s1_in_data),
        .dn_valid (s1_valid),
        .dn_ready (s2_adv),
        .dn_data  (s1_data)
    );

    assign s1_lo = s1_data[SPLIT-1:0];
    assign s1_c  = s1_data[SPLIT];
    assign s1_h0 = s1_data[SPLIT+1 +: HW];
    assign s1_h1 = s1_data[SPLIT+1+HW +: HW];

    // The top carry of the high add becomes the overflow flag.
    assign hi_sum     = {1'b0, s1_h0} + {1'b0, s1_h1} + {{HW{1'b0}}, s1_c};
    assign s2_in_data = {hi_sum, s1_lo};

    ap_pipe_slice #(.PW(S2W)) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (s1_valid),
        .up_ready (s2_adv),
        .up_data  (s2_in_data),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (s2_data)
    );

    assign out_prod = s2_data[W-1:0];
    assign out_ovf  = s2_data[W];

endmodule

// File: tb/tb_ap_cpa_pipe_24b.sv
// Self-checking bench for ap_cpa_pipe_24b: directed vectors, streaming, backpressure,
// mid-flight reset and a randomized handshake run scored against a plain 25-bit sum.
module tb_ap_cpa_pipe_24b;
    import ap_mult_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    in_valid = 1'b0;
    logic    in_ready;
    ap_row_t in_row0 = '0;
    ap_row_t in_row1 = '0;
    logic    out_valid;
    logic    out_ready = 1'b0;
    ap_row_t out_prod;
    logic    out_ovf;

    ap_cpa_pipe_24b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row0   (in_row0),
        .in_row1   (in_row1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] r0;
        logic [23:0] r1;
        logic [23:0] prod;
        logic        ovf;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] ref_sum(input logic [23:0] a, input logic [23:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    vec_t vecs[6];
    logic [24:0] q[$];
    logic [24:0] exp_v;
    logic [23:0] bp_r0[3];
    logic [23:0] bp_r1[3];
    int got;

    initial begin
        vecs[0] = '{24'h000FFF, 24'h000001, 24'h001000, 1'b0};
        vecs[1] = '{24'hFFFFFF, 24'h000001, 24'h000000, 1'b1};
        vecs[2] = '{24'h000000, 24'h000000, 24'h000000, 1'b0};
        vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1};
        vecs[4] = '{24'h123456, 24'h654321, 24'h777777, 1'b0};
        vecs[5] = '{24'hFFF000, 24'h001000, 24'h000000, 1'b1};

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_prod", out_prod, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        #6 rst_n = 1'b1;
        tick();

        // Table vectors, one beat at a time through an empty pipe
        for (int i = 0; i < 6; i++) begin
            in_row0 = vecs[i].r0; in_row1 = vecs[i].r1; in_valid = 1'b1; out_ready = 1'b1;
            #1 check("vec_in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            check("vec_lat_early", out_valid, 0);
            tick();
            check("vec_out_valid", out_valid, 1);
            check("vec_prod", out_prod, vecs[i].prod);
            check("vec_ovf", out_ovf, vecs[i].ovf);
            $display("vec %0d: %06h + %06h -> prod %06h ovf %0d", i, vecs[i].r0, vecs[i].r1, out_prod, out_ovf);
            tick();
            check("vec_drained", out_valid, 0);
        end

        // Streaming: 8 back-to-back beats, results on consecutive cycles
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_row0 = 24'(32'h010101 * (c + 1));
                in_row1 = 24'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 8) begin
                exp_v = ref_sum(24'(32'h010101 * c), 24'(c));
                check("stream_valid", out_valid, 1);
                check("stream_result", {out_ovf, out_prod}, exp_v);
                $display("stream beat %0d: prod %06h ovf %0d", c, out_prod, out_ovf);
            end
        end
        check("stream_end", out_valid, 0);

        // Backpressure: A and B fill the pipe, C waits
        bp_r0 = '{24'h000003, 24'h0ABCDE, 24'h800000};
        bp_r1 = '{24'h000004, 24'h011111, 24'h800001};
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; in_row0 = bp_r0[b]; in_row1 = bp_r1[b];
            #1 check("bp_accept_ready", in_ready, 1);
            tick();
        end
        in_row0 = bp_r0[2]; in_row1 = bp_r1[2];
        for (int s = 0; s < 3; s++) begin
            #1;
            check("bp_full_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_prod", out_prod, 24'h000007);
            tick();
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            logic take_in;
            #1;
            take_in = in_valid && in_ready;
            if (out_valid) begin
                exp_v = ref_sum(bp_r0[got], bp_r1[got]);
                check("bp_order", {out_ovf, out_prod}, exp_v);
                $display("bp out %0d: prod %06h ovf %0d", got, out_prod, out_ovf);
                got++;
            end
            tick();
            if (take_in) in_valid = 1'b0;
        end
        check("bp_count", got, 3);
        #1 check("bp_no_dup", out_valid, 0);
        tick();

        // Reset mid-flight: two beats held, asynchronous flush
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; in_row0 = 24'(b + 10); in_row1 = 24'(b + 20);
            tick();
        end
        in_valid = 1'b0;
        check("rstmid_before", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rstmid_no_emit", out_valid, 0);
            check("rstmid_ready", in_ready, 1);
        end
        $display("reset mid-flight: pipe flushed");

        // Random handshake run against a queue of expected 25-bit sums
        q.delete();
        in_valid = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic do_in;
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_row0 = 24'($urandom);
                in_row1 = 24'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_in_ready", in_ready, (q.size() < 2) || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", out_valid, 0);
                end else begin
                    exp_v = q.pop_front();
                    check("rnd_result", {out_ovf, out_prod}, exp_v);
                end
            end
            do_in = in_valid && in_ready;
            if (do_in) q.push_back(ref_sum(in_row0, in_row1));
            tick();
            if (do_in) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                exp_v = q.pop_front();
                check("rnd_drain", {out_ovf, out_prod}, exp_v);
            end
            tick();
        end
        check("rnd_left", q.size(), 0);
        $display("random run done: %0d comparisons so far", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
